// File: rtl/irrigation_zone_scheduler.sv
// Single-pump, multi-zone sprinkler scheduler: round-robin grant with min/max run,
// cooldown gap and dry-tank abort. Optional macro RUN_STATS_EN adds a run_cycles counter.
module irrigation_zone_scheduler #(
  parameter int ZONES  = 4,
  parameter int MIN_ON = 8,
  parameter int MAX_ON = 64,
  parameter int GAP    = 4,
  localparam int ZW    = $clog2(ZONES),
  localparam int TW    = $clog2(MAX_ON + 1),
  localparam int GW    = $clog2(GAP + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ZONES-1:0] earth_humidity,
  input  logic             air_humidity,
  input  logic             low_temperature,
  input  logic             mid_water_level,
  input  logic             tank_empty,
  output logic [ZONES-1:0] splinker_bomb,
  output logic [ZW-1:0]    active_zone,
  output logic             busy,
`ifdef RUN_STATS_EN
  output logic [31:0]      run_cycles,
`endif
  output logic             dry_abort
);

  typedef enum logic [1:0] {IDLE, RUN, COOLDOWN} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [ZW-1:0]    zone_q, zone_d;
  logic [ZW-1:0]    ptr_q, ptr_d;
  logic [ZONES-1:0] bomb_q, bomb_d;
  logic             busy_q, busy_d;
  logic             dry_q, dry_d;

  logic [ZONES-1:0] req;
  logic             grant_vld;
  logic [ZW-1:0]    grant_idx;
  logic [ZW-1:0]    ptr_nxt;

  assign req = ~earth_humidity & {ZONES{~air_humidity | (~low_temperature & mid_water_level)}};

  // Descending scan so the candidate closest to ptr (smallest offset) wins last.
  always_comb begin
    int j;
    j         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = ZONES - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= ZONES) j = j - ZONES;
      if (req[ZW'(j)]) begin
        grant_vld = 1'b1;
        grant_idx = ZW'(j);
      end
    end
  end

  assign ptr_nxt = (zone_q == ZW'(ZONES - 1)) ? '0 : zone_q + 1'b1;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    zone_d  = zone_q;
    ptr_d   = ptr_q;
    bomb_d  = bomb_q;
    dry_d   = 1'b0;
    case (state_q)
      IDLE: begin
        bomb_d = '0;
        if (!tank_empty && grant_vld) begin
          state_d = RUN;
          zone_d  = grant_idx;
          bomb_d  = ZONES'(1) << grant_idx;
          timer_d = '0;
        end
      end
      RUN: begin
        timer_d = timer_q + 1'b1;
        if (tank_empty || (timer_q == TW'(MAX_ON - 1)) ||
            ((timer_q >= TW'(MIN_ON - 1)) && !req[zone_q])) begin
          state_d = COOLDOWN;
          bomb_d  = '0;
          timer_d = '0;
          gap_d   = '0;
          ptr_d   = ptr_nxt;
          dry_d   = tank_empty;
        end
      end
      COOLDOWN: begin
        bomb_d = '0;
        gap_d  = gap_q + 1'b1;
        if (gap_q == GW'(GAP - 1)) begin
          state_d = IDLE;
          gap_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        bomb_d  = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      gap_q   <= '0;
      zone_q  <= '0;
      ptr_q   <= '0;
      bomb_q  <= '0;
      busy_q  <= 1'b0;
      dry_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      zone_q  <= zone_d;
      ptr_q   <= ptr_d;
      bomb_q  <= bomb_d;
      busy_q  <= busy_d;
      dry_q   <= dry_d;
    end
  end

`ifdef RUN_STATS_EN
  logic [31:0] run_cycles_q;

  always_ff @(posedge clk) begin
    if (reset)
      run_cycles_q <= '0;
    else if ((|bomb_q) && (run_cycles_q != 32'hFFFF_FFFF))
      run_cycles_q <= run_cycles_q + 32'd1;
  end

  assign run_cycles = run_cycles_q;
`endif

  assign splinker_bomb = bomb_q;
  assign active_zone   = zone_q;
  assign busy          = busy_q;
  assign dry_abort     = dry_q;

endmodule
